// File: rtl/dvi_encoder_pkg.sv
// Shared types, widths, control tokens and small helpers for the DVI TMDS encoder.
package dvi_encoder_pkg;

    localparam int unsigned COMP_W = 3;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SYM_W  = 10;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned EXT_W  = CNT_W + 1;

    typedef logic [SYM_W-1:0] tmds_sym_t;

    // Per-channel control information travelling alongside the data.
    typedef struct packed {
        logic       de;
        logic [1:0] c;
    } ctl_t;

    localparam tmds_sym_t CTRL_00 = 10'b1101010100;
    localparam tmds_sym_t CTRL_01 = 10'b0010101011;
    localparam tmds_sym_t CTRL_10 = 10'b0101010100;
    localparam tmds_sym_t CTRL_11 = 10'b1010101011;

    // Control-period token selected by {c1,c0}.
    function automatic tmds_sym_t ctrl_token(input logic [1:0] c);
        tmds_sym_t t;
        case (c)
            2'b00:   t = CTRL_00;
            2'b01:   t = CTRL_01;
            2'b10:   t = CTRL_10;
            default: t = CTRL_11;
        endcase
        return t;
    endfunction

    // 3-bit palette component to full 8-bit range by bit replication.
    function automatic logic [BYTE_W-1:0] expand(input logic [COMP_W-1:0] c);
        return {c, c, c[2:1]};
    endfunction

    // Population count of a byte.
    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS channel: transition minimisation, DC balance and running disparity.
module tmds_channel
    import dvi_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [BYTE_W-1:0] d,
    input  ctl_t              ctl,
    output tmds_sym_t         sym
);

    localparam logic signed [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic signed [EXT_W-1:0] EXT_ZERO = '0;
    localparam logic signed [EXT_W-1:0] EXT_TWO  = EXT_W'(2);
    localparam logic signed [EXT_W-1:0] EXT_BYTE = EXT_W'(BYTE_W);

    logic [3:0]              d_ones;
    logic                    use_xnor;
    logic [8:0]              q_m_c;
    logic [8:0]              q_m;
    logic [3:0]              qm_ones;
    logic                    q8;
    logic signed [EXT_W-1:0] diff;
    logic signed [EXT_W-1:0] cnt_x;
    logic signed [EXT_W-1:0] sum;
    logic signed [CNT_W-1:0] cnt;
    logic signed [CNT_W-1:0] cnt_c;
    tmds_sym_t               sym_c;

    // Stage 1: choose XOR/XNOR chain to minimise transitions.
    always_comb begin
        d_ones   = ones8(d);
        use_xnor = (d_ones > 4'd4) || ((d_ones == 4'd4) && !d[0]);
        q_m_c    = '0;
        q_m_c[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q_m_c[i] = use_xnor ? ~(q_m_c[i-1] ^ d[i]) : (q_m_c[i-1] ^ d[i]);
        end
        q_m_c[8] = ~use_xnor;
    end

    // Stage 1 pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_m <= '0;
        end else if (en) begin
            q_m <= q_m_c;
        end
    end

    // Stage 2: DC balance against running disparity, or control token.
    always_comb begin
        q8      = q_m[8];
        qm_ones = ones8(q_m[7:0]);
        diff    = $signed(EXT_W'({qm_ones, 1'b0})) - EXT_BYTE;
        cnt_x   = {cnt[CNT_W-1], cnt};
        sum     = EXT_ZERO;
        sym_c   = '0;
        cnt_c   = cnt;
        if (!ctl.de) begin
            sym_c = ctrl_token(ctl.c);
            cnt_c = CNT_ZERO;
        end else begin
            if ((cnt == CNT_ZERO) || (diff == EXT_ZERO)) begin
                sym_c = {~q8, q8, (q8 ? q_m[7:0] : ~q_m[7:0])};
                sum   = q8 ? (cnt_x + diff) : (cnt_x - diff);
            end else if (((cnt > CNT_ZERO) && (diff > EXT_ZERO)) ||
                         ((cnt < CNT_ZERO) && (diff < EXT_ZERO))) begin
                sym_c = {1'b1, q8, ~q_m[7:0]};
                sum   = cnt_x + (q8 ? EXT_TWO : EXT_ZERO) - diff;
            end else begin
                sym_c = {1'b0, q8, q_m[7:0]};
                sum   = cnt_x + diff - (q8 ? EXT_ZERO : EXT_TWO);
            end
            cnt_c = CNT_W'(sum);
        end
    end

    // Stage 2 output symbol and disparity registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym <= CTRL_00;
            cnt <= CNT_ZERO;
        end else if (en) begin
            sym <= sym_c;
            cnt <= cnt_c;
        end
    end

endmodule

// File: rtl/dvi_encoder.sv
// DVI TMDS encoder top: colour expansion, sync/active alignment, three channels.
module dvi_encoder
    import dvi_encoder_pkg::*;
#(
    parameter bit PIPE_ALIGN = 1'b1
) (
    input  logic              clk_dot4x,
    input  logic              rst,
    input  logic              pix_en,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              active,
    input  logic [COMP_W-1:0] red,
    input  logic [COMP_W-1:0] green,
    input  logic [COMP_W-1:0] blue,
    output tmds_sym_t         tmds_r,
    output tmds_sym_t         tmds_g,
    output tmds_sym_t         tmds_b
);

    ctl_t              ctl_in;
    ctl_t              ctl_b;
    ctl_t              ctl_gr;
    logic [BYTE_W-1:0] d_r;
    logic [BYTE_W-1:0] d_g;
    logic [BYTE_W-1:0] d_b;

    // Expand palette components and gather the raw control fields.
    always_comb begin
        d_r       = expand(red);
        d_g       = expand(green);
        d_b       = expand(blue);
        ctl_in.de = active;
        ctl_in.c  = {vsync, hsync};
    end

    generate
        if (PIPE_ALIGN) begin : g_align
            ctl_t ctl_q;

            // Delay control by one strobe to line up with the stage 1 data register.
            always_ff @(posedge clk_dot4x or posedge rst) begin
                if (rst) begin
                    ctl_q <= '0;
                end else if (pix_en) begin
                    ctl_q <= ctl_in;
                end
            end

            assign ctl_b = ctl_q;
        end else begin : g_direct
            assign ctl_b = ctl_in;
        end
    endgenerate

    // Green and red carry no control bits, only the shared data-enable.
    always_comb begin
        ctl_gr.de = ctl_b.de;
        ctl_gr.c  = 2'b00;
    end

    tmds_channel u_chan_b (
        .clk (clk_dot4x),
        .rst (rst),
        .en  (pix_en),
        .d   (d_b),
        .ctl (ctl_b),
        .sym (tmds_b)
    );

    tmds_channel u_chan_g (
        .clk (clk_dot4x),
        .rst (rst),
        .en  (pix_en),
        .d   (d_g),
        .ctl (ctl_gr),
        .sym (tmds_g)
    );

    tmds_channel u_chan_r (
        .clk (clk_dot4x),
        .rst (rst),
        .en  (pix_en),
        .d   (d_r),
        .ctl (ctl_gr),
        .sym (tmds_r)
    );

endmodule

// File: tb/tb_dvi_encoder.sv
// Self-checking bench for dvi_encoder against a behavioural TMDS model.
module tb_dvi_encoder;

    localparam int LAT = 2;

    typedef struct {
        bit         de;
        bit         hs;
        bit         vs;
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } sample_t;

    logic       clk;
    logic       rst;
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic [2:0] red;
    logic [2:0] green;
    logic [2:0] blue;
    logic [9:0] tmds_r;
    logic [9:0] tmds_g;
    logic [9:0] tmds_b;

    int n_checks;
    int n_pass;

    logic [9:0] ctrl_tok [4] = '{10'b1101010100, 10'b0010101011,
                                 10'b0101010100, 10'b1010101011};

    sample_t    pend_q[$];
    sample_t    last_out;
    int         mcnt    [3];
    logic [9:0] exp_sym [3];

    dvi_encoder #(.PIPE_ALIGN(1'b1)) dut (
        .clk_dot4x (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .hsync     (hsync),
        .vsync     (vsync),
        .active    (active),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .tmds_r    (tmds_r),
        .tmds_g    (tmds_g),
        .tmds_b    (tmds_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] o;
        d    = s[9] ? ~s[7:0] : s[7:0];
        o    = '0;
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

    // Encode one sample for one channel (0=blue, 1=green, 2=red) from the TMDS rules.
    task automatic model_encode(input int ch, input sample_t s, output logic [9:0] sym);
        logic [2:0] comp;
        logic [1:0] cc;
        logic [7:0] d;
        logic [8:0] q;
        int         n1;
        int         n0;
        bit         xn;
        comp = (ch == 0) ? s.b : ((ch == 1) ? s.g : s.r);
        cc   = (ch == 0) ? {s.vs, s.hs} : 2'b00;
        if (!s.de) begin
            sym      = ctrl_tok[cc];
            mcnt[ch] = 0;
        end else begin
            d  = expand3(comp);
            n1 = $countones(d);
            xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            q    = '0;
            q[0] = d[0];
            for (int i = 1; i < 8; i++) begin
                q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
            end
            q[8] = !xn;
            n1 = $countones(q[7:0]);
            n0 = 8 - n1;
            if (mcnt[ch] == 0 || n1 == n0) begin
                sym = {~q[8], q[8], (q[8] ? q[7:0] : ~q[7:0])};
                mcnt[ch] += q[8] ? (n1 - n0) : (n0 - n1);
            end else if ((mcnt[ch] > 0 && n1 > n0) || (mcnt[ch] < 0 && n0 > n1)) begin
                sym = {1'b1, q[8], ~q[7:0]};
                mcnt[ch] += 2 * int'(q[8]) + (n0 - n1);
            end else begin
                sym = {1'b0, q[8], q[7:0]};
                mcnt[ch] += (n1 - n0) - 2 * int'(!q[8]);
            end
        end
    endtask

    task automatic model_reset();
        sample_t z;
        z = '{de: 1'b0, hs: 1'b0, vs: 1'b0, r: 3'd0, g: 3'd0, b: 3'd0};
        pend_q.delete();
        for (int i = 0; i < LAT - 1; i++) pend_q.push_back(z);
        last_out = z;
        for (int ch = 0; ch < 3; ch++) begin
            mcnt[ch]    = 0;
            exp_sym[ch] = ctrl_tok[0];
        end
    endtask

    task automatic model_strobe();
        sample_t s;
        s = '{de: active, hs: hsync, vs: vsync, r: red, g: green, b: blue};
        pend_q.push_back(s);
        if (pend_q.size() >= LAT) begin
            last_out = pend_q.pop_front();
            for (int ch = 0; ch < 3; ch++) model_encode(ch, last_out, exp_sym[ch]);
        end
    endtask

    task automatic compare_all();
        int cb;
        int cg;
        int cr;
        cb = dut.u_chan_b.cnt;
        cg = dut.u_chan_g.cnt;
        cr = dut.u_chan_r.cnt;
        check("sym_b", int'(tmds_b), int'(exp_sym[0]));
        check("sym_g", int'(tmds_g), int'(exp_sym[1]));
        check("sym_r", int'(tmds_r), int'(exp_sym[2]));
        check("cnt_b", cb, mcnt[0]);
        check("cnt_g", cg, mcnt[1]);
        check("cnt_r", cr, mcnt[2]);
        check("cnt_range_b", int'(cb >= -8 && cb <= 8), 1);
        check("cnt_range_g", int'(cg >= -8 && cg <= 8), 1);
        check("cnt_range_r", int'(cr >= -8 && cr <= 8), 1);
        if (last_out.de) begin
            check("decode_b", int'(tmds_decode(tmds_b)), int'(expand3(last_out.b)));
            check("decode_g", int'(tmds_decode(tmds_g)), int'(expand3(last_out.g)));
            check("decode_r", int'(tmds_decode(tmds_r)), int'(expand3(last_out.r)));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (pix_en) model_strobe();
        compare_all();
    endtask

    // Assert reset just after an edge, check the asynchronous effect, release one cycle later.
    task automatic do_reset();
        int cb;
        rst = 1'b1;
        #1;
        cb = dut.u_chan_b.cnt;
        check("rst_sym_b", int'(tmds_b), int'(10'b1101010100));
        check("rst_sym_g", int'(tmds_g), int'(10'b1101010100));
        check("rst_sym_r", int'(tmds_r), int'(10'b1101010100));
        check("rst_cnt_b", cb, 0);
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rand_inputs(input bit allow_idle);
        pix_en = allow_idle ? ($urandom_range(0, 3) != 0) : 1'b1;
        active = ($urandom_range(0, 15) != 0);
        hsync  = $urandom_range(0, 1) != 0;
        vsync  = $urandom_range(0, 1) != 0;
        red    = 3'($urandom_range(0, 7));
        green  = 3'($urandom_range(0, 7));
        blue   = 3'($urandom_range(0, 7));
    endtask

    initial begin
        int strobes;
        int iter;
        int cr;
        bit rst_done;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        pix_en   = 1'b0;
        hsync    = 1'b0;
        vsync    = 1'b0;
        active   = 1'b0;
        red      = 3'd0;
        green    = 3'd0;
        blue     = 3'd0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Control period tokens, blue carries hsync
        pix_en = 1'b1;
        repeat (3) cycle();
        check("ctl00_b", int'(tmds_b), int'(10'b1101010100));
        check("ctl00_g", int'(tmds_g), int'(10'b1101010100));
        check("ctl00_r", int'(tmds_r), int'(10'b1101010100));
        hsync = 1'b1;
        repeat (2) cycle();
        check("ctl01_b", int'(tmds_b), int'(10'b0010101011));
        check("ctl01_g", int'(tmds_g), int'(10'b1101010100));
        check("ctl01_r", int'(tmds_r), int'(10'b1101010100));
        vsync = 1'b1;
        repeat (2) cycle();
        check("ctl11_b", int'(tmds_b), int'(10'b1010101011));

        // Blue=000 run: disparity walk -8, +2, -6
        do_reset();
        active = 1'b1;
        hsync  = 1'b0;
        vsync  = 1'b0;
        blue   = 3'd0;
        green  = 3'd0;
        red    = 3'd0;
        pix_en = 1'b1;
        cycle();
        check("fill_b", int'(tmds_b), int'(10'b1101010100));
        cycle();
        check("blk1_b", int'(tmds_b), int'(10'b0100000000));
        check("blk1_cnt", int'(dut.u_chan_b.cnt), -8);
        cycle();
        check("blk2_b", int'(tmds_b), int'(10'b1111111111));
        check("blk2_cnt", int'(dut.u_chan_b.cnt), 2);
        cycle();
        check("blk3_b", int'(tmds_b), int'(10'b0100000000));
        check("blk3_cnt", int'(dut.u_chan_b.cnt), -6);

        // Red=111 first symbol
        do_reset();
        red = 3'd7;
        repeat (2) cycle();
        cr = dut.u_chan_r.cnt;
        check("wht_r", int'(tmds_r), int'(10'b1000000000));
        check("wht_cnt", cr, -8);

        // Freeze: pix_en low for 10 cycles mid-line, inputs wiggling
        for (int i = 0; i < 20; i++) begin
            rand_inputs(1'b0);
            active = 1'b1;
            cycle();
        end
        for (int i = 0; i < 10; i++) begin
            rand_inputs(1'b0);
            pix_en = 1'b0;
            cycle();
        end
        for (int i = 0; i < 20; i++) begin
            rand_inputs(1'b0);
            cycle();
        end

        // Random traffic with a reset pulse in the middle of the active period
        strobes  = 0;
        iter     = 0;
        rst_done = 1'b0;
        while (strobes < 10000 && iter < 40000) begin
            rand_inputs(1'b1);
            cycle();
            if (pix_en) strobes++;
            iter++;
            if (!rst_done && strobes >= 5000) begin
                rst_done = 1'b1;
                active   = 1'b1;
                pix_en   = 1'b1;
                do_reset();
                cycle();
                check("refill1_b", int'(tmds_b), int'(10'b1101010100));
                check("refill1_r", int'(tmds_r), int'(10'b1101010100));
                cycle();
            end
        end
        check("rand_budget", int'(strobes >= 10000), 1);
        check("rst_pulse_seen", int'(rst_done), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
